// File: rtl/cart_pkg.sv
// Shared loader states and iNES format constants.
package cart_pkg;

  typedef enum logic [2:0] {
    HEADER,
    CHECK,
    TRAINER,
    PRG,
    CHR,
    DONE,
    ERROR
  } ld_state_t;

  localparam logic [31:0] INES_MAGIC  = 32'h1A53454E;  // "NES\x1A", byte 0 in bits [7:0]
  localparam int          PRG_UNIT    = 16384;
  localparam int          CHR_UNIT    = 8192;
  localparam int          TRAINER_LEN = 512;

endpackage

// File: rtl/pow2_mask.sv
// Combinational smear-right: turns (size - 1) into the power-of-two address mask covering size.
module pow2_mask #(
  parameter int W = 8
) (
  input  logic [W-1:0] size_m1,
  output logic [W-1:0] mask
);

  // Bit gi of the mask is set when any bit at or above gi is set in size-1.
  for (genvar gi = 0; gi < W; gi++) begin : g_smear
    assign mask[gi] = |size_m1[W-1:gi];
  end

endmodule

// File: rtl/ines_cart_loader.sv
// iNES image loader: captures the 16-byte header, validates it, skips an optional trainer,
// streams PRG then CHR bytes into cart memory and publishes the mapper configuration.
module ines_cart_loader
  import cart_pkg::*;
#(
  parameter int  PRG_ROM_DEPTH = 17,
  parameter int  CHR_ROM_DEPTH = 15,
  parameter int  PRG_RAM_DEPTH = 13,
  localparam int ADDR_W = (PRG_ROM_DEPTH > CHR_ROM_DEPTH) ? PRG_ROM_DEPTH : CHR_ROM_DEPTH,
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic                     clk_cpu,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     wr_en,
  input  logic                     wr_ready,
  output logic                     wr_chr,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [7:0]               wr_data,
  output logic [PRG_ROM_DEPTH-1:0] prg_mask,
  output logic [CHR_ROM_DEPTH-1:0] chr_mask,
  output logic [PRG_RAM_DEPTH-1:0] prgram_mask,
  output logic                     mirrorv,
  output logic                     chr_ram,
  output logic                     prg_ram,
  output logic [7:0]               mapper_id,
  output logic                     cart_rst,
  output logic                     done,
  output logic                     error
);

  ld_state_t state_reg, state_next;
  logic [CNT_W-1:0] count_reg;

  // Decoded header fields (only the bits the loader and mapper care about)
  logic [31:0] magic_reg;
  logic [7:0]  prg_units_reg, chr_units_reg;
  logic        mirror_bit_reg, prgram_bit_reg, trainer_bit_reg;
  logic [3:0]  mapper_lo_reg, mapper_hi_reg;

  logic [31:0]              prg_bytes, chr_bytes;
  logic                     fault;
  logic [PRG_ROM_DEPTH-1:0] prg_size_m1, prg_mask_calc;
  logic [CHR_ROM_DEPTH-1:0] chr_size_m1, chr_mask_calc;
  logic [CNT_W-1:0]         prg_total, chr_total, xfer_total;
  logic                     wr_fire, last_write, room, slot_free, accept;

  assign prg_bytes = 32'(prg_units_reg) * 32'(PRG_UNIT);
  assign chr_bytes = 32'(chr_units_reg) * 32'(CHR_UNIT);
  assign fault = (magic_reg != INES_MAGIC) || (prg_units_reg == 8'd0) ||
                 (prg_bytes > (32'd1 << PRG_ROM_DEPTH)) ||
                 (chr_bytes > (32'd1 << CHR_ROM_DEPTH));

  // Sizes are bounded by the depth check, so size-1 always fits the mask width.
  assign prg_size_m1 = PRG_ROM_DEPTH'(prg_bytes - 32'd1);
  assign chr_size_m1 = CHR_ROM_DEPTH'(chr_bytes - 32'd1);

  pow2_mask #(.W(PRG_ROM_DEPTH)) u_prg_mask (.size_m1(prg_size_m1), .mask(prg_mask_calc));
  pow2_mask #(.W(CHR_ROM_DEPTH)) u_chr_mask (.size_m1(chr_size_m1), .mask(chr_mask_calc));

  assign prg_total  = CNT_W'(prg_bytes);
  assign chr_total  = CNT_W'(chr_bytes);
  assign xfer_total = (state_reg == CHR) ? chr_total : prg_total;

  // count_reg numbers bytes accepted; wr_addr names the write still outstanding.
  assign wr_fire    = wr_en && wr_ready;
  assign last_write = wr_fire && ({1'b0, wr_addr} == (xfer_total - CNT_W'(1)));
  assign room       = count_reg < xfer_total;
  assign slot_free  = !wr_en || wr_ready;
  assign accept     = in_valid && in_ready;

  assign cart_rst = (state_reg != DONE);
  assign done     = (state_reg == DONE);
  assign error    = (state_reg == ERROR);

  // State register
  always_ff @(posedge clk_cpu) begin
    if (rst) state_reg <= HEADER;
    else     state_reg <= state_next;
  end

  // Next-state and input handshake
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      HEADER: begin
        in_ready = 1'b1;
        if (in_valid && count_reg == CNT_W'(15)) state_next = CHECK;
      end
      CHECK: state_next = fault ? ERROR : (trainer_bit_reg ? TRAINER : PRG);
      TRAINER: begin
        in_ready = 1'b1;
        if (in_valid && count_reg == CNT_W'(TRAINER_LEN - 1)) state_next = PRG;
      end
      PRG, CHR: begin
        in_ready = room && slot_free;
        if (last_write)
          state_next = (state_reg == PRG && chr_units_reg != 8'd0) ? CHR : DONE;
      end
      DONE, ERROR: in_ready = 1'b1;
      default: state_next = HEADER;
    endcase
  end

  // Header capture, counters, write skid register and config latch
  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      count_reg       <= '0;
      wr_en           <= 1'b0;
      wr_chr          <= 1'b0;
      wr_addr         <= '0;
      wr_data         <= '0;
      magic_reg       <= '0;
      prg_units_reg   <= '0;
      chr_units_reg   <= '0;
      mirror_bit_reg  <= 1'b0;
      prgram_bit_reg  <= 1'b0;
      trainer_bit_reg <= 1'b0;
      mapper_lo_reg   <= '0;
      mapper_hi_reg   <= '0;
      prg_mask        <= '0;
      chr_mask        <= '0;
      prgram_mask     <= '0;
      mirrorv         <= 1'b0;
      chr_ram         <= 1'b0;
      prg_ram         <= 1'b0;
      mapper_id       <= '0;
    end else begin
      if (wr_fire) wr_en <= 1'b0;
      case (state_reg)
        HEADER: if (in_valid) begin
          case (count_reg[3:0])
            4'd0: magic_reg[7:0]   <= in_data;
            4'd1: magic_reg[15:8]  <= in_data;
            4'd2: magic_reg[23:16] <= in_data;
            4'd3: magic_reg[31:24] <= in_data;
            4'd4: prg_units_reg    <= in_data;
            4'd5: chr_units_reg    <= in_data;
            4'd6: begin
              mapper_lo_reg   <= in_data[7:4];
              trainer_bit_reg <= in_data[2];
              prgram_bit_reg  <= in_data[1];
              mirror_bit_reg  <= in_data[0];
            end
            4'd7: mapper_hi_reg <= in_data[7:4];
            default: ;
          endcase
          count_reg <= (count_reg == CNT_W'(15)) ? '0 : count_reg + CNT_W'(1);
        end
        CHECK: if (!fault) begin
          prg_mask    <= prg_mask_calc;
          chr_mask    <= (chr_units_reg == 8'd0) ? '1 : chr_mask_calc;
          prgram_mask <= '1;
          mirrorv     <= mirror_bit_reg;
          chr_ram     <= (chr_units_reg == 8'd0);
          prg_ram     <= prgram_bit_reg;
          mapper_id   <= {mapper_hi_reg, mapper_lo_reg};
        end
        TRAINER: if (in_valid)
          count_reg <= (count_reg == CNT_W'(TRAINER_LEN - 1)) ? '0 : count_reg + CNT_W'(1);
        PRG, CHR: begin
          if (accept) begin
            wr_en     <= 1'b1;
            wr_addr   <= ADDR_W'(count_reg);
            wr_data   <= in_data;
            wr_chr    <= (state_reg == CHR);
            count_reg <= count_reg + CNT_W'(1);
          end
          // No byte can be accepted in the cycle PRG finishes (room is exhausted).
          if (last_write && state_reg == PRG) count_reg <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ines_cart_loader.sv
// Scoreboard bench for ines_cart_loader: random images, expected writes queued at image build,
// a monitor pops and compares every accepted memory write.
module tb_ines_cart_loader;

  localparam int PD = 17;
  localparam int CD = 15;
  localparam int RD = 13;
  localparam int AW = 17;

  logic          clk_cpu = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic          wr_ready = 1'b1;
  logic          wr_chr;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [PD-1:0] prg_mask;
  logic [CD-1:0] chr_mask;
  logic [RD-1:0] prgram_mask;
  logic          mirrorv, chr_ram, prg_ram, cart_rst, done, error;
  logic [7:0]    mapper_id;

  ines_cart_loader #(.PRG_ROM_DEPTH(PD), .CHR_ROM_DEPTH(CD), .PRG_RAM_DEPTH(RD)) dut (
    .clk_cpu(clk_cpu), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_chr(wr_chr), .wr_addr(wr_addr), .wr_data(wr_data),
    .prg_mask(prg_mask), .chr_mask(chr_mask), .prgram_mask(prgram_mask), .mirrorv(mirrorv),
    .chr_ram(chr_ram), .prg_ram(prg_ram), .mapper_id(mapper_id), .cart_rst(cart_rst),
    .done(done), .error(error));

  always #5 clk_cpu = ~clk_cpu;

  typedef struct packed {
    logic          chr;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] img[$];
  int         checks = 0;
  int         failures = 0;
  int         writes_seen = 0;
  logic       throttle = 1'b0;

  // Expected configuration for the image currently being loaded
  bit            e_fault;
  logic [PD-1:0] e_prg_mask;
  logic [CD-1:0] e_chr_mask;
  logic          e_mirrorv, e_chr_ram, e_prg_ram;
  logic [7:0]    e_mapper;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int pow2_ceil(input int n);
    int p = 1;
    while (p < n) p = p * 2;
    return p;
  endfunction

  // Reference model: lay out the image and list every memory write it should cause.
  task automatic build(input logic [31:0] magic, input logic [7:0] b4, input logic [7:0] b5,
                       input logic [7:0] b6, input logic [7:0] b7);
    logic [7:0] d;
    int prg_n, chr_n;
    img.delete();
    exp_q.delete();
    prg_n = int'(b4) * 16384;
    chr_n = int'(b5) * 8192;
    e_fault = (magic != 32'h1A53454E) || (b4 == 0) || (prg_n > (1 << PD)) || (chr_n > (1 << CD));
    for (int i = 0; i < 4; i++) img.push_back(magic[8*i +: 8]);
    img.push_back(b4); img.push_back(b5); img.push_back(b6); img.push_back(b7);
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
    if (e_fault) begin
      e_prg_mask = '0; e_chr_mask = '0; e_mirrorv = 0; e_chr_ram = 0; e_prg_ram = 0; e_mapper = 0;
      for (int i = 0; i < 64; i++) img.push_back(8'($urandom));
    end else begin
      e_prg_mask = PD'(pow2_ceil(prg_n) - 1);
      e_chr_ram  = (b5 == 0);
      e_chr_mask = e_chr_ram ? '1 : CD'(pow2_ceil(chr_n) - 1);
      e_mirrorv  = b6[0];
      e_prg_ram  = b6[1];
      e_mapper   = {b7[7:4], b6[7:4]};
      if (b6[2]) for (int i = 0; i < 512; i++) img.push_back(8'($urandom));
      for (int i = 0; i < prg_n; i++) begin
        d = 8'($urandom); img.push_back(d); exp_q.push_back('{1'b0, AW'(i), d});
      end
      for (int i = 0; i < chr_n; i++) begin
        d = 8'($urandom); img.push_back(d); exp_q.push_back('{1'b1, AW'(i), d});
      end
    end
  endtask

  // Offer img[first..last-1] one byte at a time, honouring in_ready, within a cycle budget.
  task automatic send(input string tag, input int first, input int last);
    int idx = first;
    int cyc = 0;
    bit acc;
    while (idx < last && cyc < (last - first) * 8 + 1000) begin
      in_data  = img[idx];
      in_valid = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk_cpu);
      acc = in_valid && in_ready;
      @(posedge clk_cpu);
      #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_bytes_sent"}, idx, last);
  endtask

  task automatic wait_end(input string tag);
    int c = 0;
    while (!(done || error) && c < 500) begin
      @(negedge clk_cpu);
      c++;
    end
    @(negedge clk_cpu);
    check({tag, "_terminated"}, done || error, 1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk_cpu);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_config(input string tag);
    check({tag, "_done"}, done, !e_fault);
    check({tag, "_error"}, error, e_fault);
    check({tag, "_cart_rst"}, cart_rst, e_fault);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_prg_mask"}, prg_mask, e_prg_mask);
    check({tag, "_chr_mask"}, chr_mask, e_chr_mask);
    check({tag, "_prgram_mask"}, prgram_mask, e_fault ? 0 : 32'h1FFF);
    check({tag, "_mirrorv"}, mirrorv, e_mirrorv);
    check({tag, "_chr_ram"}, chr_ram, e_chr_ram);
    check({tag, "_prg_ram"}, prg_ram, e_prg_ram);
    check({tag, "_mapper_id"}, mapper_id, e_mapper);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  // Memory-side throttling, changed just after each active edge
  initial begin
    forever begin
      @(posedge clk_cpu);
      #1 wr_ready = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: every write the memory accepts must be the next expected one
  initial begin
    wr_t e;
    forever begin
      @(negedge clk_cpu);
      if (!rst && wr_en && wr_ready) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {6'b0, wr_chr, wr_addr, wr_data}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("write", {6'b0, wr_chr, wr_addr, wr_data}, {6'b0, e});
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [31:0] err_magic[4];
    logic [7:0]  err_b4[4];
    logic [7:0]  err_b5[4];

    // Reset state
    do_reset();
    @(negedge clk_cpu);
    check("rst_cart_rst", cart_rst, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_prg_mask", prg_mask, 0);
    check("rst_mapper_id", mapper_id, 0);
    $display("reset: cart_rst=%0b done=%0b error=%0b", cart_rst, done, error);

    // 48KB PRG, CHR RAM; abort with reset part way through PRG
    @(posedge clk_cpu); #1;
    build(32'h1A53454E, 8'd3, 8'd0, 8'h00, 8'h00);
    w0 = writes_seen;
    send("abort", 0, 16 + 2000);
    repeat (4) @(negedge clk_cpu);
    check("abort_prg_mask", prg_mask, 32'h0FFFF);
    check("abort_chr_mask", chr_mask, 32'h7FFF);
    check("abort_chr_ram", chr_ram, 1);
    check("abort_cart_rst", cart_rst, 1);
    check("abort_writes", writes_seen - w0, 2000);
    @(posedge clk_cpu); #1;
    do_reset();
    @(negedge clk_cpu);
    check("abort_rst_prg_mask", prg_mask, 0);
    check("abort_rst_chr_ram", chr_ram, 0);
    check("abort_rst_wr_en", wr_en, 0);
    check("abort_rst_in_ready", in_ready, 1);
    $display("abort: writes=%0d prg_mask cleared=%0b", writes_seen - w0, prg_mask == 0);

    // NROM 32KB PRG / 8KB CHR, unthrottled, loaded after the aborted image
    @(posedge clk_cpu); #1;
    build(32'h1A53454E, 8'd2, 8'd1, 8'h01, 8'h00);
    w0 = writes_seen;
    send("nrom", 0, img.size());
    wait_end("nrom");
    check_config("nrom");
    check("nrom_writes", writes_seen - w0, 40960);
    $display("nrom: bytes=%0d writes=%0d done=%0b", img.size(), writes_seen - w0, done);

    // MMC1-style with trainer and CHR RAM, throttled on both sides, trailing bytes discarded
    do_reset();
    @(posedge clk_cpu); #1;
    build(32'h1A53454E, 8'd1, 8'd0, 8'h16, 8'h00);
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
    throttle = 1'b1;
    w0 = writes_seen;
    send("mmc1", 0, img.size());
    wait_end("mmc1");
    repeat (3) @(negedge clk_cpu);
    check_config("mmc1");
    check("mmc1_writes", writes_seen - w0, 16384);
    throttle = 1'b0;
    $display("mmc1: bytes=%0d writes=%0d mapper=%0d chr_ram=%0b", img.size(), writes_seen - w0,
             mapper_id, chr_ram);

    // Rejected headers: bad magic, PRG too large, CHR too large, zero PRG
    err_magic = '{32'h0053454E, 32'h1A53454E, 32'h1A53454E, 32'h1A53454E};
    err_b4    = '{8'd2, 8'd16, 8'd1, 8'd0};
    err_b5    = '{8'd1, 8'd0, 8'd5, 8'd1};
    for (int t = 0; t < 4; t++) begin
      do_reset();
      @(posedge clk_cpu); #1;
      build(err_magic[t], err_b4[t], err_b5[t], 8'h00, 8'h00);
      w0 = writes_seen;
      send($sformatf("err%0d_hdr", t), 0, 16);
      @(negedge clk_cpu);
      check($sformatf("err%0d_check_in_ready", t), in_ready, 0);
      @(posedge clk_cpu); #1;
      send($sformatf("err%0d_drain", t), 16, img.size());
      wait_end($sformatf("err%0d", t));
      check_config($sformatf("err%0d", t));
      check($sformatf("err%0d_writes", t), writes_seen - w0, 0);
      $display("err%0d: b4=%0d b5=%0d error=%0b writes=%0d", t, err_b4[t], err_b5[t], error,
               writes_seen - w0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
